sprite_reg_bank: RTL and testbench
==================================

SPRITE_REG_BANK -- requirements
Module: sprite_reg_bank

Interface
REQ-001 The block SHALL have parameter NUM_OBJ, default 16, meaning the number of sprite slots (1..64).
REQ-002 The block SHALL have parameter COORD_W, default 10, meaning the coordinate width in bits (1..16).
REQ-003 The block SHALL have parameter BASE_ADDR, default 12'hE00, meaning the first word address of the bank in the 12-bit data map.
REQ-004 Port clk  in  1  single system clock; all logic on its rising edge.
REQ-005 Port reset  in  1  asynchronous, active-low reset.
REQ-006 Port wEn  in  1  CPU write enable.
REQ-007 Port addr  in  12  CPU word address.
REQ-008 Port dataIn  in  32  CPU write data.
REQ-009 Port dataOut  out  32  CPU read data, registered.
REQ-010 Port hit  out  1  registered; high when dataOut carries bank data.
REQ-011 Port frame_start  in  1  single-cycle pulse at the start of vertical blank.
REQ-012 Port obj_x  out  NUM_OBJ*COORD_W  active X coordinates; slot i at [i*COORD_W +: COORD_W].
REQ-013 Port obj_y  out  NUM_OBJ*COORD_W  active Y coordinates, packed the same way.
REQ-014 Port obj_en  out  NUM_OBJ  active visibility bits; bit i belongs to slot i.

Function
REQ-015 The address map SHALL be as follows, with all offsets relative to BASE_ADDR:
- 2i = slot i X word: bit31 = enable, [COORD_W-1:0] = X.
- 2i+1 = slot i Y word.
- 2*NUM_OBJ = CTRL.
- 2*NUM_OBJ+1 = STATUS.
REQ-016 CPU writes SHALL update only the shadow copy; coordinate bits above COORD_W are discarded, and enable is taken from bit 31.
REQ-017 Writing CTRL with bit0=1 SHALL set commit_pending; writing CTRL with bit1=1 SHALL clear all shadow enable bits in that cycle.
REQ-018 On frame_start with commit_pending=1, the block SHALL copy the entire shadow to active in one cycle and clear commit_pending.
REQ-019 On frame_start with commit_pending=0, active SHALL be unchanged.
REQ-020 frame_cnt (16 bit) SHALL increment on every frame_start and wrap from 16'hFFFF to 0.
REQ-021 A read SHALL have one-cycle latency: dataOut and hit are valid on the clk edge after addr is presented.
- Slot reads return the shadow values, zero-extended, with bit31 = enable.
- STATUS reads return {frame_cnt, 15'b0, commit_pending}.
- CTRL reads return 0.
REQ-022 An out-of-range address SHALL produce hit=0 and dataOut=0, and writes to it SHALL be ignored.
REQ-023 A CTRL commit write in the same cycle as frame_start SHALL NOT be applied that frame; commit_pending SHALL read 1 afterwards, and the commit applies at the next frame_start.
REQ-024 A shadow write in the same cycle as a commit copy SHALL leave active holding the pre-write shadow value; the new value lands only in shadow.
REQ-025 Writing CTRL with bit0=1 while commit_pending=1 SHALL leave commit_pending=1 and cause only a single copy.
REQ-026 obj_x, obj_y and obj_en SHALL be driven directly from active registers, with no combinational path from CPU ports.

Reset
REQ-027 While reset=0, the block SHALL immediately clear all shadow and active registers, commit_pending, frame_cnt, dataOut and hit, independent of clk.
REQ-028 After reset, obj_x=0, obj_y=0 and obj_en=0, and a commit in progress SHALL be discarded.
REQ-029 Reset release SHALL be synchronised externally, and the first edge after release SHALL be treated as normal operation.

Structure
REQ-030 Package sprite_pkg SHALL hold the CTRL/STATUS offset constants, the CTRL bit indices and the enable bit position (31).
REQ-031 One sub-module, sprite_slot, SHALL hold the shadow and active X/Y/enable registers for one slot and SHALL be instantiated NUM_OBJ times.
REQ-032 The address decode, CTRL/STATUS logic and read mux SHALL be in sprite_reg_bank.

Verification
REQ-033 NUM_OBJ=4, BASE_ADDR=12'hE00: write E00=32'h8000_0123 and E01=32'h45, then frame_start with no commit.
-> obj_en=0 and obj_x=0; a read of E00 returns 32'h8000_0123 with hit=1 one cycle later.
REQ-034 Continue from REQ-033: write E08=1, then frame_start.
-> slot0 shows X=10'h123, Y=10'h045, en=1; STATUS reads 32'h0002_0000.
REQ-035 Write E08=1 in the same cycle as frame_start.
-> active unchanged and STATUS bit0=1; after the next frame_start, active is updated and bit0=0.
REQ-036 Write E02=32'h8000_03FF in the commit-copy cycle.
-> active slot1 keeps its old value and shadow reads 32'h8000_03FF.
REQ-037 Issue 65536 frame_start pulses, then read addresses E09 and F00.
-> frame_cnt wraps to 0; F00 returns dataOut=0, hit=0.
REQ-038 Assert reset=0 mid-frame after a pending commit.
-> all outputs are 0 asynchronously, and the next frame_start after release copies nothing.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants for the sprite register bank: CTRL/STATUS placement and bit positions.
package sprite_pkg;

    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;
    localparam int ENABLE_BIT      = 31;

    // CTRL and STATUS sit directly after the 2*NUM_OBJ slot words
    function automatic int ctrlOffset(input int numObj);
        return 2 * numObj;
    endfunction

    function automatic int statusOffset(input int numObj);
        return 2 * numObj + 1;
    endfunction

endpackage

// File: rtl/sprite_slot.sv
// One sprite slot: CPU-visible shadow X/Y/enable plus the active copy seen by the renderer.
module sprite_slot
    import sprite_pkg::*;
#(
    parameter int COORD_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wrX,
    input  logic               wrY,
    input  logic [COORD_W-1:0] wrCoord,
    input  logic               wrEn,
    input  logic               clearEn,
    input  logic               commit,
    output logic [COORD_W-1:0] shX,
    output logic [COORD_W-1:0] shY,
    output logic               shEn,
    output logic [COORD_W-1:0] actX,
    output logic [COORD_W-1:0] actY,
    output logic               actEn
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shX   <= '0;
            shY   <= '0;
            shEn  <= 1'b0;
            actX  <= '0;
            actY  <= '0;
            actEn <= 1'b0;
        end else begin
            if (wrX) begin
                shX  <= wrCoord;
                shEn <= wrEn;
            end
            if (wrY) begin
                shY <= wrCoord;
            end
            if (clearEn) begin
                shEn <= 1'b0;
            end
            // Copy samples the pre-edge shadow, so a same-cycle CPU write stays shadow-only
            if (commit) begin
                actX  <= shX;
                actY  <= shY;
                actEn <= shEn;
            end
        end
    end

endmodule

// File: rtl/sprite_reg_bank.sv
// Double-buffered sprite position/visibility registers with frame-synchronous commit.
module sprite_reg_bank
    import sprite_pkg::*;
#(
    parameter int          NUM_OBJ   = 16,
    parameter int          COORD_W   = 10,
    parameter logic [11:0] BASE_ADDR = 12'hE00
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wEn,
    input  logic [11:0]                addr,
    input  logic [31:0]                dataIn,
    output logic [31:0]                dataOut,
    output logic                       hit,
    input  logic                       frame_start,
    output logic [NUM_OBJ*COORD_W-1:0] obj_x,
    output logic [NUM_OBJ*COORD_W-1:0] obj_y,
    output logic [NUM_OBJ-1:0]         obj_en
);

    logic [12:0]        offset_p0;
    logic               inRange_p0;
    logic               isCtrl_p0;
    logic               isStatus_p0;
    logic               ctrlCommitWr;
    logic               ctrlClearWr;
    logic               commitCopy;
    logic               commitPending;
    logic [15:0]        frameCnt;
    logic [31:0]        readWord_p0;
    logic               unusedDataIn;

    logic [COORD_W-1:0] shX  [NUM_OBJ];
    logic [COORD_W-1:0] shY  [NUM_OBJ];
    logic               shEn [NUM_OBJ];

    // 13-bit offset keeps the range check correct when the bank ends near the top of the map
    assign offset_p0    = {1'b0, addr} - {1'b0, BASE_ADDR};
    assign inRange_p0   = (addr >= BASE_ADDR) && (offset_p0 <= 13'(statusOffset(NUM_OBJ)));
    assign isCtrl_p0    = inRange_p0 && (offset_p0 == 13'(ctrlOffset(NUM_OBJ)));
    assign isStatus_p0  = inRange_p0 && (offset_p0 == 13'(statusOffset(NUM_OBJ)));
    assign ctrlCommitWr = wEn && isCtrl_p0 && dataIn[CTRL_COMMIT_BIT];
    assign ctrlClearWr  = wEn && isCtrl_p0 && dataIn[CTRL_CLEAR_BIT];
    assign commitCopy   = frame_start && commitPending;
    assign unusedDataIn = ^dataIn;

    for (genvar i = 0; i < NUM_OBJ; i++) begin : gSlot
        sprite_slot #(
            .COORD_W(COORD_W)
        ) uSlot (
            .clk     (clk),
            .reset   (reset),
            .wrX     (wEn && inRange_p0 && (offset_p0 == 13'(2 * i))),
            .wrY     (wEn && inRange_p0 && (offset_p0 == 13'(2 * i + 1))),
            .wrCoord (dataIn[COORD_W-1:0]),
            .wrEn    (dataIn[ENABLE_BIT]),
            .clearEn (ctrlClearWr),
            .commit  (commitCopy),
            .shX     (shX[i]),
            .shY     (shY[i]),
            .shEn    (shEn[i]),
            .actX    (obj_x[i*COORD_W +: COORD_W]),
            .actY    (obj_y[i*COORD_W +: COORD_W]),
            .actEn   (obj_en[i])
        );
    end

    always_comb begin
        readWord_p0 = '0;
        if (isStatus_p0) begin
            readWord_p0 = {frameCnt, 15'b0, commitPending};
        end else if (inRange_p0) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                if (offset_p0 == 13'(2 * i)) begin
                    readWord_p0[COORD_W-1:0] = shX[i];
                    readWord_p0[ENABLE_BIT]  = shEn[i];
                end else if (offset_p0 == 13'(2 * i + 1)) begin
                    readWord_p0[COORD_W-1:0] = shY[i];
                end
            end
        end
    end

    // ---- stage p0 -> registered read port and control state ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            commitPending <= 1'b0;
            frameCnt      <= '0;
            dataOut       <= '0;
            hit           <= 1'b0;
        end else begin
            dataOut <= readWord_p0;
            hit     <= inRange_p0;
            if (frame_start) begin
                frameCnt      <= frameCnt + 16'd1;
                // A commit request arriving with frame_start waits for the following frame
                commitPending <= ctrlCommitWr;
            end else if (ctrlCommitWr) begin
                commitPending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sprite_reg_bank.sv
// Self-checking bench for sprite_reg_bank: directed vector table, corner sequences and random traffic.
module tb_sprite_reg_bank;

    localparam int          N    = 4;
    localparam int          CW   = 10;
    localparam logic [11:0] BASE = 12'hE00;

    logic            clk = 1'b0;
    logic            reset;
    logic            wEn;
    logic [11:0]     addr;
    logic [31:0]     dataIn;
    logic [31:0]     dataOut;
    logic            hit;
    logic            frame_start;
    logic [N*CW-1:0] obj_x;
    logic [N*CW-1:0] obj_y;
    logic [N-1:0]    obj_en;

    int checks = 0;
    int errors = 0;

    sprite_reg_bank #(
        .NUM_OBJ  (N),
        .COORD_W  (CW),
        .BASE_ADDR(BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wEn        (wEn),
        .addr       (addr),
        .dataIn     (dataIn),
        .dataOut    (dataOut),
        .hit        (hit),
        .frame_start(frame_start),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .obj_en     (obj_en)
    );

    always #5 clk = ~clk;

    // Reference model: two plain arrays (shadow, active) plus pending flag and frame counter
    logic [CW-1:0] mShX [N];
    logic [CW-1:0] mShY [N];
    logic          mShEn[N];
    logic [CW-1:0] mActX[N];
    logic [CW-1:0] mActY[N];
    logic          mActEn[N];
    logic          mPend;
    logic [15:0]   mCnt;
    logic [31:0]   mRd;
    logic          mHit;

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            mShX[i] = '0; mShY[i] = '0; mShEn[i] = 1'b0;
            mActX[i] = '0; mActY[i] = '0; mActEn[i] = 1'b0;
        end
        mPend = 1'b0;
        mCnt  = '0;
        mRd   = '0;
        mHit  = 1'b0;
    endtask

    task automatic modelStep(input logic we, input logic [11:0] a, input logic [31:0] d, input logic fs);
        int  off;
        int  s;
        logic commitWr;
        logic clearWr;
        off = int'(a) - int'(BASE);
        mRd = '0;
        mHit = 1'b0;
        if (off >= 0 && off < 2 * N + 2) begin
            mHit = 1'b1;
            if (off < 2 * N) begin
                s = off / 2;
                if (off % 2 == 0) mRd = {mShEn[s], 21'b0, mShX[s]};
                else              mRd = {22'b0, mShY[s]};
            end else if (off == 2 * N + 1) begin
                mRd = {mCnt, 15'b0, mPend};
            end
        end
        commitWr = we && (off == 2 * N) && d[0];
        clearWr  = we && (off == 2 * N) && d[1];
        if (fs) begin
            if (mPend) begin
                for (int i = 0; i < N; i++) begin
                    mActX[i] = mShX[i]; mActY[i] = mShY[i]; mActEn[i] = mShEn[i];
                end
            end
            mPend = commitWr;
            mCnt  = mCnt + 16'd1;
        end else if (commitWr) begin
            mPend = 1'b1;
        end
        if (we && off >= 0 && off < 2 * N) begin
            s = off / 2;
            if (off % 2 == 0) begin
                mShX[s] = d[CW-1:0]; mShEn[s] = d[31];
            end else begin
                mShY[s] = d[CW-1:0];
            end
        end
        if (clearWr) begin
            for (int i = 0; i < N; i++) mShEn[i] = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic checkModel(input string tag);
        logic [N*CW-1:0] ex;
        logic [N*CW-1:0] ey;
        logic [N-1:0]    ee;
        for (int i = 0; i < N; i++) begin
            ex[i*CW +: CW] = mActX[i];
            ey[i*CW +: CW] = mActY[i];
            ee[i]          = mActEn[i];
        end
        check({tag, " dataOut"}, 64'(dataOut), 64'(mRd));
        check({tag, " hit"},     64'(hit),     64'(mHit));
        check({tag, " obj_x"},   64'(obj_x),   64'(ex));
        check({tag, " obj_y"},   64'(obj_y),   64'(ey));
        check({tag, " obj_en"},  64'(obj_en),  64'(ee));
    endtask

    task automatic cycle(input logic we, input logic [11:0] a, input logic [31:0] d, input logic fs,
                         input string tag);
        @(negedge clk);
        wEn = we; addr = a; dataIn = d; frame_start = fs;
        @(posedge clk);
        modelStep(we, a, d, fs);
        #1;
        checkModel(tag);
    endtask

    typedef struct {
        logic        we;
        logic [11:0] a;
        logic [31:0] d;
        logic        fs;
        logic        chk;
        logic [31:0] expD;
        logic        expH;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [11:0] ra;
        logic [31:0] rd;

        vecs[0]  = '{1'b1, 12'hE00, 32'h8000_0123, 1'b0, 1'b0, 32'h0,         1'b0};
        vecs[1]  = '{1'b1, 12'hE01, 32'h0000_0045, 1'b0, 1'b0, 32'h0,         1'b0};
        vecs[2]  = '{1'b0, 12'h000, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0};
        vecs[3]  = '{1'b0, 12'hE00, 32'h0,         1'b0, 1'b1, 32'h8000_0123, 1'b1};
        vecs[4]  = '{1'b1, 12'hE08, 32'h0000_0001, 1'b0, 1'b0, 32'h0,         1'b0};
        vecs[5]  = '{1'b0, 12'h000, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0};
        vecs[6]  = '{1'b0, 12'hE09, 32'h0,         1'b0, 1'b1, 32'h0002_0000, 1'b1};
        vecs[7]  = '{1'b0, 12'hE00, 32'h0,         1'b0, 1'b1, 32'h8000_0123, 1'b1};
        vecs[8]  = '{1'b0, 12'hE01, 32'h0,         1'b0, 1'b1, 32'h0000_0045, 1'b1};
        vecs[9]  = '{1'b1, 12'hE08, 32'h0000_0001, 1'b1, 1'b0, 32'h0,         1'b0};
        vecs[10] = '{1'b0, 12'hE09, 32'h0,         1'b0, 1'b1, 32'h0003_0001, 1'b1};
        vecs[11] = '{1'b1, 12'hE02, 32'h8000_03FF, 1'b1, 1'b0, 32'h0,         1'b0};
        vecs[12] = '{1'b0, 12'hE02, 32'h0,         1'b0, 1'b1, 32'h8000_03FF, 1'b1};
        vecs[13] = '{1'b0, 12'hE09, 32'h0,         1'b0, 1'b1, 32'h0004_0000, 1'b1};
        vecs[14] = '{1'b0, 12'hE08, 32'h0,         1'b0, 1'b1, 32'h0,         1'b1};
        vecs[15] = '{1'b0, 12'hF00, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0};

        reset = 1'b0; wEn = 1'b0; addr = '0; dataIn = '0; frame_start = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        check("reset dataOut", 64'(dataOut), 64'h0);
        check("reset hit",     64'(hit),     64'h0);
        check("reset obj_x",   64'(obj_x),   64'h0);
        check("reset obj_y",   64'(obj_y),   64'h0);
        check("reset obj_en",  64'(obj_en),  64'h0);
        @(negedge clk);
        reset = 1'b1;

        // Directed table: basic write/read, commit, commit-with-frame, write-during-copy
        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].fs, $sformatf("vec%0d", i));
            if (vecs[i].chk) begin
                check($sformatf("vec%0d table dataOut", i), 64'(dataOut), 64'(vecs[i].expD));
                check($sformatf("vec%0d table hit", i),     64'(hit),     64'(vecs[i].expH));
            end
            if (i == 3) begin
                check("nocommit obj_en", 64'(obj_en), 64'h0);
                check("nocommit obj_x",  64'(obj_x),  64'h0);
            end
        end
        check("slot0 X",   64'(obj_x[9:0]),   64'h123);
        check("slot0 Y",   64'(obj_y[9:0]),   64'h045);
        check("obj_en",    64'(obj_en),       64'h1);
        check("slot1 X",   64'(obj_x[19:10]), 64'h0);

        // CTRL clear drops shadow enables but keeps coordinates; commit then hides slot0
        cycle(1'b1, 12'hE08, 32'h0000_0002, 1'b0, "clear");
        cycle(1'b0, 12'hE00, 32'h0, 1'b0, "clearrd");
        check("clear shadow read", 64'(dataOut), 64'h0000_0123);
        cycle(1'b1, 12'hE08, 32'h0000_0001, 1'b0, "commit2");
        cycle(1'b1, 12'hE08, 32'h0000_0001, 1'b0, "commit2b");
        cycle(1'b0, 12'h000, 32'h0, 1'b1, "frame2");
        check("clear obj_en", 64'(obj_en), 64'h0);
        cycle(1'b0, 12'h000, 32'h0, 1'b1, "frame3");
        cycle(1'b0, 12'hE09, 32'h0, 1'b0, "single copy");
        check("single copy pending", 64'(dataOut[0]), 64'h0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) != 0) ra = 12'(int'(BASE) + int'($urandom_range(0, 2 * N + 1)));
            else                           ra = 12'($urandom);
            rd = $urandom;
            if (ra == BASE + 12'(2 * N)) rd[1] = ($urandom_range(0, 7) == 0);
            cycle(1'($urandom_range(0, 1)), ra, rd, ($urandom_range(0, 3) == 0), "rand");
        end

        // Frame counter wrap from a fresh reset
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 65536; i++) cycle(1'b0, 12'h000, 32'h0, 1'b1, "wrap");
        cycle(1'b0, 12'hE09, 32'h0, 1'b0, "wrapst");
        check("wrap status", 64'(dataOut), 64'h0);
        check("wrap hit",    64'(hit),     64'h1);
        cycle(1'b0, 12'hF00, 32'h0, 1'b0, "oob");
        check("oob dataOut", 64'(dataOut), 64'h0);
        check("oob hit",     64'(hit),     64'h0);

        // Asynchronous reset with a commit pending
        cycle(1'b1, 12'hE00, 32'h8000_0155, 1'b0, "pre1");
        cycle(1'b1, 12'hE08, 32'h0000_0001, 1'b0, "pre2");
        cycle(1'b0, 12'h000, 32'h0, 1'b1, "pre3");
        cycle(1'b1, 12'hE02, 32'h8000_0001, 1'b0, "pre4");
        cycle(1'b1, 12'hE08, 32'h0000_0001, 1'b0, "pre5");
        cycle(1'b0, 12'hE00, 32'h0, 1'b0, "pre6");
        check("pre reset obj_en", 64'(obj_en), 64'h1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async dataOut", 64'(dataOut), 64'h0);
        check("async hit",     64'(hit),     64'h0);
        check("async obj_x",   64'(obj_x),   64'h0);
        check("async obj_y",   64'(obj_y),   64'h0);
        check("async obj_en",  64'(obj_en),  64'h0);
        modelReset();
        wEn = 1'b0; addr = '0; dataIn = '0; frame_start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b0, 12'h000, 32'h0, 1'b1, "postrst");
        check("postrst obj_en", 64'(obj_en), 64'h0);
        check("postrst obj_x",  64'(obj_x),  64'h0);
        cycle(1'b0, 12'hE09, 32'h0, 1'b0, "postst");
        check("postrst status", 64'(dataOut), 64'h0001_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
